// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - MIPS control decode with EX/MEM/WB control pipeline registers
// Optional load-use stall detection is enabled by defining CTRL_LOADUSE_EN.
module ctrl_pipeline #(
    parameter int ALUOP_W = 4,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic               flush,
    input  logic               hold,
    output logic               stall_out,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic               ex_signextend,
    output logic               ex_branch,
    output logic [1:0]         ex_shift,
    output logic [1:0]         ex_pc_source,
    output logic [REG_W-1:0]   ex_dest,
    output logic               mem_readmem,
    output logic               mem_writemem,
    output logic               mem_regwrite,
    output logic               mem_memtoreg,
    output logic [REG_W-1:0]   mem_dest,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_dest,
    output logic               illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);
    localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(14);

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               signextend;
        logic               branch;
        logic [1:0]         shift;
        logic [1:0]         pc_source;
        logic               readmem;
        logic               writemem;
        logic               regwrite;
        logic               memtoreg;
        logic [REG_W-1:0]   dest;
    } ctrl_t;

    ctrl_t dec, bubble, ex_q;
    logic  regdst, is_jal, reads_rt, is_illegal, hazard, load_illegal;

    always_comb begin
        dec        = '0;
        dec.aluop  = ALU_NOP;
        regdst     = 1'b0;
        is_jal     = 1'b0;
        reads_rt   = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            6'h00: begin
                regdst   = 1'b1;
                reads_rt = 1'b1;
                dec.regwrite = 1'b1;
                case (func)
                    6'h20: dec.aluop = ALU_ADD;
                    6'h21: dec.aluop = ALU_ADDU;
                    6'h22: dec.aluop = ALU_SUB;
                    6'h23: dec.aluop = ALU_SUBU;
                    6'h24: dec.aluop = ALU_AND;
                    6'h25: dec.aluop = ALU_OR;
                    6'h26: dec.aluop = ALU_XOR;
                    6'h27: dec.aluop = ALU_NOR;
                    6'h2A: dec.aluop = ALU_SLT;
                    6'h2B: dec.aluop = ALU_SLTU;
                    6'h00: begin dec.aluop = ALU_SLL; dec.shift = 2'b01; end
                    6'h02: begin dec.aluop = ALU_SRL; dec.shift = 2'b01; end
                    6'h03: begin dec.aluop = ALU_SRA; dec.shift = 2'b01; end
                    6'h08: begin
                        dec.regwrite  = 1'b0;
                        dec.branch    = 1'b1;
                        dec.pc_source = 2'b01;
                    end
                    default: dec.regwrite = 1'b0;
                endcase
            end
            6'h08: begin dec.aluop = ALU_ADD;  dec.alusrc = 1'b1; dec.signextend = 1'b1; dec.regwrite = 1'b1; end
            6'h09: begin dec.aluop = ALU_ADDU; dec.alusrc = 1'b1; dec.signextend = 1'b1; dec.regwrite = 1'b1; end
            6'h0A: begin dec.aluop = ALU_SLT;  dec.alusrc = 1'b1; dec.signextend = 1'b1; dec.regwrite = 1'b1; end
            6'h0C: begin dec.aluop = ALU_AND;  dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            6'h0D: begin dec.aluop = ALU_OR;   dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            6'h0F: begin dec.aluop = ALU_LUI;  dec.alusrc = 1'b1; dec.shift = 2'b10; dec.regwrite = 1'b1; end
            6'h23: begin
                dec.aluop    = ALU_ADD;
                dec.alusrc   = 1'b1;
                dec.signextend = 1'b1;
                dec.readmem  = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
            end
            6'h2B: begin
                dec.aluop    = ALU_ADD;
                dec.alusrc   = 1'b1;
                dec.signextend = 1'b1;
                dec.writemem = 1'b1;
                reads_rt     = 1'b1;
            end
            6'h04, 6'h05: begin
                dec.aluop = ALU_SUB; dec.signextend = 1'b1; dec.branch = 1'b1; reads_rt = 1'b1;
            end
            6'h01, 6'h07: begin dec.aluop = ALU_SLT; dec.signextend = 1'b1; dec.branch = 1'b1; end
            6'h02: dec.pc_source = 2'b10;
            6'h03: begin dec.pc_source = 2'b10; dec.regwrite = 1'b1; is_jal = 1'b1; end
            default: is_illegal = 1'b1;
        endcase
        dec.dest = regdst ? rd : (is_jal ? REG_W'(31) : rt);
        // Writes to register 0 are architecturally discarded.
        if (dec.dest == '0)
            dec.regwrite = 1'b0;
    end

    always_comb begin
        bubble       = '0;
        bubble.aluop = ALU_NOP;
    end

`ifdef CTRL_LOADUSE_EN
    assign hazard = id_valid && ex_q.readmem && (ex_q.dest != '0) &&
                    ((ex_q.dest == rs) || (reads_rt && (ex_q.dest == rt)));
`else
    logic unused_loaduse;
    assign unused_loaduse = ^{rs, reads_rt};
    assign hazard = 1'b0;
`endif

    assign stall_out    = hazard && !flush;
    assign load_illegal = id_valid && !flush && !hazard && is_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            mem_readmem  <= 1'b0;
            mem_writemem <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_dest     <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_dest      <= '0;
            illegal      <= 1'b0;
            illegal_cnt  <= '0;
        end else if (hold) begin
            illegal <= 1'b0;
        end else begin
            if (flush || !id_valid || hazard || is_illegal)
                ex_q <= bubble;
            else
                ex_q <= dec;
            illegal <= load_illegal;
            if (load_illegal && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + 1'b1;
            mem_readmem  <= ex_q.readmem;
            mem_writemem <= ex_q.writemem;
            mem_regwrite <= ex_q.regwrite;
            mem_memtoreg <= ex_q.memtoreg;
            mem_dest     <= ex_q.dest;
            wb_regwrite  <= mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_dest      <= mem_dest;
        end
    end

    assign ex_aluop      = ex_q.aluop;
    assign ex_alusrc     = ex_q.alusrc;
    assign ex_signextend = ex_q.signextend;
    assign ex_branch     = ex_q.branch;
    assign ex_shift      = ex_q.shift;
    assign ex_pc_source  = ex_q.pc_source;
    assign ex_dest       = ex_q.dest;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - scoreboard bench for ctrl_pipeline
module tb_ctrl_pipeline;
    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2;
`ifdef CTRL_LOADUSE_EN
    localparam logic LU = 1'b1;
`else
    localparam logic LU = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic id_valid = 1'b0, flush = 1'b0, hold = 1'b0;
    logic [5:0] opcode = '0, func = '0;
    logic [4:0] rs = '0, rt = '0, rd = '0;

    logic stall_out, ex_alusrc, ex_signextend, ex_branch, illegal;
    logic [3:0] ex_aluop;
    logic [1:0] ex_shift, ex_pc_source;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic mem_readmem, mem_writemem, mem_regwrite, mem_memtoreg, wb_regwrite, wb_memtoreg;
    logic [7:0] illegal_cnt;

    logic d2_stall, d2_alusrc, d2_signext, d2_branch, d2_illegal;
    logic [3:0] d2_aluop;
    logic [1:0] d2_shift, d2_pc;
    logic [4:0] d2_exd, d2_memd, d2_wbd;
    logic d2_mr, d2_mw, d2_mrw, d2_mm, d2_wrw, d2_wm;
    logic [1:0] d2_cnt;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush), .hold(hold), .stall_out(stall_out),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_signextend(ex_signextend),
        .ex_branch(ex_branch), .ex_shift(ex_shift), .ex_pc_source(ex_pc_source),
        .ex_dest(ex_dest), .mem_readmem(mem_readmem), .mem_writemem(mem_writemem),
        .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_dest(mem_dest),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    ctrl_pipeline #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush), .hold(hold), .stall_out(d2_stall),
        .ex_aluop(d2_aluop), .ex_alusrc(d2_alusrc), .ex_signextend(d2_signext),
        .ex_branch(d2_branch), .ex_shift(d2_shift), .ex_pc_source(d2_pc),
        .ex_dest(d2_exd), .mem_readmem(d2_mr), .mem_writemem(d2_mw),
        .mem_regwrite(d2_mrw), .mem_memtoreg(d2_mm), .mem_dest(d2_memd),
        .wb_regwrite(d2_wrw), .wb_memtoreg(d2_wm), .wb_dest(d2_wbd),
        .illegal(d2_illegal), .illegal_cnt(d2_cnt)
    );

    typedef struct packed {
        logic       stall;
        logic [3:0] aluop;
        logic [6:0] exb;
        logic [4:0] exd;
        logic [3:0] memb;
        logic [4:0] memd;
        logic [1:0] wbb;
        logic [4:0] wbd;
        logic       ill;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t e(input logic st, input logic [3:0] op, input logic [6:0] xb,
                               input logic [4:0] xd, input logic [3:0] mb, input logic [4:0] md,
                               input logic [1:0] wb, input logic [4:0] wd, input logic il,
                               input logic [7:0] c, input logic [1:0] c2);
        exp_t r;
        r = '{st, op, xb, xd, mb, md, wb, wd, il, c, c2};
        return r;
    endfunction

    // Inputs change 1 ns after the rising edge; expectations describe the following falling edge.
    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic fl, input logic hd, input exp_t x);
        @(posedge clk);
        #1;
        id_valid = v; opcode = op; func = fn; rs = s; rt = t; rd = d; flush = fl; hold = hd;
        sb.push_back(x);
    endtask

    task automatic idle(input logic hd, input exp_t x);
        step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, hd, x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("stall_out", 32'(stall_out), 32'(x.stall));
                chk("ex_aluop", 32'(ex_aluop), 32'(x.aluop));
                chk("ex_ctrl", 32'({ex_alusrc, ex_signextend, ex_branch, ex_shift, ex_pc_source}), 32'(x.exb));
                chk("ex_dest", 32'(ex_dest), 32'(x.exd));
                chk("mem_ctrl", 32'({mem_readmem, mem_writemem, mem_regwrite, mem_memtoreg}), 32'(x.memb));
                chk("mem_dest", 32'(mem_dest), 32'(x.memd));
                chk("wb_ctrl", 32'({wb_regwrite, wb_memtoreg}), 32'(x.wbb));
                chk("wb_dest", 32'(wb_dest), 32'(x.wbd));
                chk("illegal", 32'(illegal), 32'(x.ill));
                chk("illegal_cnt", 32'(illegal_cnt), 32'(x.cnt));
                chk("illegal_cnt_w2", 32'(d2_cnt), 32'(x.cnt2));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall_out), 32'd0);
        chk({tag, "_ex_aluop"}, 32'(ex_aluop), 32'(NOP));
        chk({tag, "_ex_ctrl"}, 32'({ex_alusrc, ex_signextend, ex_branch, ex_shift, ex_pc_source}), 32'd0);
        chk({tag, "_ex_dest"}, 32'(ex_dest), 32'd0);
        chk({tag, "_mem"}, 32'({mem_readmem, mem_writemem, mem_regwrite, mem_memtoreg, mem_dest}), 32'd0);
        chk({tag, "_wb"}, 32'({wb_regwrite, wb_memtoreg, wb_dest}), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_cnt"}, 32'(illegal_cnt), 32'd0);
        chk({tag, "_cnt_w2"}, 32'(d2_cnt), 32'd0);
    endtask

    initial begin : driver
        #2;
        chk_reset_outputs("reset_init");
        #15 rst = 1'b0;

        // ADDI $8
        step(1'b1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, ADD, 7'b1100000, 8, 4'b0, 0, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0010, 8, 2'b0, 0, 0, 0, 0));
        // LW $9 then ADD $11,$9,$10
        step(1'b1, 6'h23, 6'h00, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b10, 8, 0, 0, 0));
        step(1'b1, 6'h00, 6'h20, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0, e(LU, ADD, 7'b1100000, 9, 4'b0, 0, 2'b0, 0, 0, 0, 0));
`ifdef CTRL_LOADUSE_EN
        step(1'b1, 6'h00, 6'h20, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0, e(0, NOP, 7'b0, 0, 4'b1011, 9, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, ADD, 7'b0, 11, 4'b0, 0, 2'b11, 9, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0010, 11, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b10, 11, 0, 0, 0));
`else
        idle(1'b0, e(0, ADD, 7'b0, 11, 4'b1011, 9, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0010, 11, 2'b11, 9, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b10, 11, 0, 0, 0));
`endif
        // BEQ then a flushed ADDI
        step(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, 0, 0, 0));
        step(1'b1, 6'h08, 6'h00, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, e(0, SUB, 7'b0110000, 2, 4'b0, 0, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 2, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 2, 0, 0, 0));
        // LW $3 then dependent ADD with flush: flush beats the stall
        step(1'b1, 6'h23, 6'h00, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, 0, 0, 0));
        step(1'b1, 6'h00, 6'h20, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, e(0, ADD, 7'b1100000, 3, 4'b0, 0, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b1011, 3, 2'b0, 0, 0, 0, 0));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b11, 3, 0, 0, 0));
        // Five illegal opcodes
        for (int i = 0; i < 5; i++)
            step(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                 e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, (i > 0), 8'(i), (i > 3) ? 2'd3 : 2'(i)));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, 1, 5, 3));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, 0, 5, 3));
        // JAL with three hold cycles
        step(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, 0, 5, 3));
        for (int i = 0; i < 3; i++)
            idle(1'b1, e(0, NOP, 7'b0000010, 31, 4'b0, 0, 2'b0, 0, 0, 5, 3));
        idle(1'b0, e(0, NOP, 7'b0000010, 31, 4'b0, 0, 2'b0, 0, 0, 5, 3));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0010, 31, 2'b0, 0, 0, 5, 3));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b10, 31, 0, 5, 3));
        idle(1'b0, e(0, NOP, 7'b0, 0, 4'b0, 0, 2'b0, 0, 0, 5, 3));

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-pipeline
        @(posedge clk);
        #1;
        id_valid = 1'b1; opcode = 6'h08; rt = 5'd8;
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        chk("pre_reset_ex_dest", 32'(ex_dest), 32'd8);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("reset_async");
        #3 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
